tap_nav_sequencer: RTL and testbench
====================================

Name: tap_nav_sequencer

Overview:
- Drives the TMS input of the TAP controller so that the TAP reaches a requested stable state, then optionally holds it there for N clocks.
- Keeps a shadow copy of the TAP state using the IEEE 1149.1 16-state encoding, which matches state_obs[3:0].
- Sits between the test-access host logic and the TAP, and owns the TAP's TMS pulse line.

Parameters:
- HOLD_W, 8, width of the hold-cycle count.
- INIT_CYCLES, 5, number of TMS=1 clocks issued after reset to force the TAP into Test-Logic-Reset.

Ports:
- GCLK  in  1  global clock; all state updates on the rising edge.
- TRST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_target  in  4  target TAP state code.
- cmd_hold  in  HOLD_W  clocks to remain in the target after arrival (0 = none).
- tms_out  out  1  registered TMS value for the TAP.
- tap_state  out  4  shadow TAP state.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse when a target is rejected.

Behaviour:
- State encoding (package constants):
  - TLR=F, RTI=C, SELDR=7, CAPDR=6, SHDR=2, EX1DR=1, PSDR=3, EX2DR=0, UPDDR=5
  - SELIR=4, CAPIR=E, SHIR=A, EX1IR=9, PSIR=B, EX2IR=8, UPDIR=D
- Legal targets are the stable states only: TLR, RTI, SHDR, PSDR, SHIR, PSIR.
- Reset (TRST=1, asynchronous):
  - FSM=INIT, tap_state=TLR, tms_out=1, cmd_ready=0, busy=1, done=0, err=0, counters=0.
  - A reset asserted mid-command aborts the command. No done pulse is issued.
- Shadow update: every GCLK edge, tap_state <= tap_next(tap_state, tms_out), using the standard 1149.1 transition table.
- Registered TMS: tms_out <= nav_tms(tap_state_next, tgt), computed from the post-edge shadow state.
- FSM states:
  - INIT: tms_out=1 for INIT_CYCLES clocks, then go to IDLE. tap_state is TLR throughout.
  - IDLE: cmd_ready=1, busy=0. tms_out is the park value: 1 if tap_state=TLR, else 0.
    - On cmd_valid with a legal target, latch tgt and hold, drop cmd_ready, go to MOVE. If tap_state already equals tgt, go straight to HOLD.
    - On cmd_valid with an illegal target: err pulse, stay in IDLE, tms_out unchanged.
  - MOVE: drive nav_tms each clock. When tap_state_next equals tgt, go to HOLD if hold>0, else go to IDLE with a done pulse.
  - HOLD: drive the park TMS for hold clocks (counter decrements, saturating at 0), then go to IDLE with a done pulse.
- nav_tms(cur, tgt) follows the shortest path:
  - TLR: 1 if tgt=TLR, else 0.
  - RTI, SHxR, PSxR: 0 if cur=tgt, else 1.
  - SELDR: 0 if tgt in {SHDR, PSDR}, else 1. SELIR: 0 if tgt in {SHIR, PSIR}, else 1.
  - CAPxR: 0 if tgt=SHxR, else 1.
  - EX1xR: 0 if tgt=PSxR, else 1.
  - EX2xR: 0 if tgt=SHxR, else 1.
  - UPDxR: 0 if tgt=RTI, else 1.
- Path length between any two legal targets is at most 7 clocks.
- Handshake: a command is accepted on a cycle with cmd_valid and cmd_ready both high. cmd_valid while busy is ignored; it is not queued.
- Park in SHxR continues shifting. Bounding that is the host's responsibility.

Optional Feature:
- Macro: TAP_OBS_CHECK_EN.
- Defined:
  - Adds input obs_state[3:0], the registered state_obs from the TAP, and output obs_mismatch (sticky).
  - obs_state is compared against tap_state delayed one clock. Any difference sets obs_mismatch, which TRST clears.
  - In INIT, the comparison is masked.
- Undefined: neither port exists and there is no compare logic.

Decomposition:
- Package tap_nav_pkg holds:
  - the 4-bit state-code constants and the tap_state_t typedef;
  - the FSM enum {INIT, IDLE, MOVE, HOLD};
  - functions tap_next() and nav_tms().
- One sub-module, tap_shadow_fsm: the registered shadow state plus the transition function, reusable by the observability checker.

Test Plan:
- Reset release: tms_out=1 for 5 clocks with cmd_ready=0, then cmd_ready=1, tap_state=F, and tms_out stays 1 in park.
- From TLR, goto RTI (C) with hold 0: TMS sequence 0; done on the arrival cycle; park TMS=0.
- From RTI, goto SHDR (2) with hold 3: TMS 1,0,0 through states 7, 6, 2; then 3 clocks of TMS=0; done; tap_state=2.
- From SHDR, goto SHIR (A): TMS 1,1,1,1,0,0 through states 1, 5, 7, 4, E, A; busy for 6 clocks, then done.
- Illegal target 7 in IDLE: err pulse for one clock, no TMS change, cmd_ready stays 1. Asserting cmd_valid mid-MOVE changes neither the target nor the path.
- TRST pulse in the middle of the SHIR walk: immediately tap_state=F and tms_out=1; INIT replays 5 clocks; no done pulse.

Source files
------------

// File: rtl/tap_nav_pkg.sv
// Shared TAP state codes (1149.1 state_obs encoding), sequencer FSM type,
// the 1149.1 transition function and the shortest-path TMS selector.
package tap_nav_pkg;

    typedef logic [3:0] tap_state_t;

    localparam tap_state_t TLR   = 4'hF;
    localparam tap_state_t RTI   = 4'hC;
    localparam tap_state_t SELDR = 4'h7;
    localparam tap_state_t CAPDR = 4'h6;
    localparam tap_state_t SHDR  = 4'h2;
    localparam tap_state_t EX1DR = 4'h1;
    localparam tap_state_t PSDR  = 4'h3;
    localparam tap_state_t EX2DR = 4'h0;
    localparam tap_state_t UPDDR = 4'h5;
    localparam tap_state_t SELIR = 4'h4;
    localparam tap_state_t CAPIR = 4'hE;
    localparam tap_state_t SHIR  = 4'hA;
    localparam tap_state_t EX1IR = 4'h9;
    localparam tap_state_t PSIR  = 4'hB;
    localparam tap_state_t EX2IR = 4'h8;
    localparam tap_state_t UPDIR = 4'hD;

    typedef enum logic [1:0] {INIT, IDLE, MOVE, HOLD} seq_state_t;

    function automatic tap_state_t tap_next(input tap_state_t cur, input logic tms);
        tap_state_t nxt;
        case (cur)
            TLR:     nxt = tms ? TLR   : RTI;
            RTI:     nxt = tms ? SELDR : RTI;
            SELDR:   nxt = tms ? SELIR : CAPDR;
            CAPDR:   nxt = tms ? EX1DR : SHDR;
            SHDR:    nxt = tms ? EX1DR : SHDR;
            EX1DR:   nxt = tms ? UPDDR : PSDR;
            PSDR:    nxt = tms ? EX2DR : PSDR;
            EX2DR:   nxt = tms ? UPDDR : SHDR;
            UPDDR:   nxt = tms ? SELDR : RTI;
            SELIR:   nxt = tms ? TLR   : CAPIR;
            CAPIR:   nxt = tms ? EX1IR : SHIR;
            SHIR:    nxt = tms ? EX1IR : SHIR;
            EX1IR:   nxt = tms ? UPDIR : PSIR;
            PSIR:    nxt = tms ? EX2IR : PSIR;
            EX2IR:   nxt = tms ? UPDIR : SHIR;
            UPDIR:   nxt = tms ? SELDR : RTI;
            default: nxt = TLR;
        endcase
        return nxt;
    endfunction

    function automatic logic is_stable(input tap_state_t s);
        return (s == TLR) || (s == RTI) || (s == SHDR) ||
               (s == PSDR) || (s == SHIR) || (s == PSIR);
    endfunction

    // Only TLR needs TMS=1 to stay put; every other stable state holds on 0.
    function automatic logic park_tms(input tap_state_t s);
        return (s == TLR);
    endfunction

    function automatic logic nav_tms(input tap_state_t cur, input tap_state_t tgt);
        logic tms;
        case (cur)
            TLR:                         tms = (tgt == TLR);
            RTI, SHDR, PSDR, SHIR, PSIR: tms = (cur != tgt);
            SELDR:                       tms = !((tgt == SHDR) || (tgt == PSDR));
            SELIR:                       tms = !((tgt == SHIR) || (tgt == PSIR));
            CAPDR, EX2DR:                tms = (tgt != SHDR);
            CAPIR, EX2IR:                tms = (tgt != SHIR);
            EX1DR:                       tms = (tgt != PSDR);
            EX1IR:                       tms = (tgt != PSIR);
            UPDDR, UPDIR:                tms = (tgt != RTI);
            default:                     tms = 1'b1;
        endcase
        return tms;
    endfunction

endpackage

// File: rtl/tap_shadow_fsm.sv
// Registered shadow of the TAP controller state, advanced by the TMS it sees;
// also exposes the post-edge state so callers can plan the next TMS.
module tap_shadow_fsm
    import tap_nav_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tms,
    output tap_state_t o_state,
    output tap_state_t o_state_next
);

    tap_state_t r_state;
    tap_state_t w_state_next;

    assign w_state_next = tap_next(r_state, i_tms);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= TLR;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign o_state      = r_state;
    assign o_state_next = w_state_next;

endmodule

// File: rtl/tap_nav_sequencer.sv
// Walks the TAP to a requested stable state via registered TMS, then dwells there.
// States: INIT | forcing TLR; IDLE | parked, accepting; MOVE | walking; HOLD | dwelling. Option: TAP_OBS_CHECK_EN.
module tap_nav_sequencer
    import tap_nav_pkg::*;
#(
    parameter int HOLD_W      = 8,
    parameter int INIT_CYCLES = 5
) (
    input  logic              GCLK,
    input  logic              TRST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_target,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              tms_out,
    output logic [3:0]        tap_state,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef TAP_OBS_CHECK_EN
    ,
    input  logic [3:0]        obs_state,
    output logic              obs_mismatch
`endif
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    seq_state_t        r_fsm;
    seq_state_t        w_fsm_next;
    logic              r_tms;
    logic              w_tms_next;
    logic              r_done;
    logic              w_done_next;
    logic              r_err;
    logic              w_err_next;
    logic              w_load;
    tap_state_t        r_tgt;
    logic [HOLD_W-1:0] r_hold;
    logic [INIT_W-1:0] r_init_cnt;
    tap_state_t        w_tap;
    tap_state_t        w_tap_next;

    tap_shadow_fsm u_shadow (
        .i_clk        (GCLK),
        .i_rst        (TRST),
        .i_tms        (r_tms),
        .o_state      (w_tap),
        .o_state_next (w_tap_next)
    );

    always_ff @(posedge GCLK or posedge TRST) begin
        if (TRST) begin
            r_fsm <= INIT;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // TMS is planned from the post-edge shadow state so the pin is never a cycle late.
    always_comb begin
        w_fsm_next  = r_fsm;
        w_tms_next  = park_tms(w_tap_next);
        w_done_next = 1'b0;
        w_err_next  = 1'b0;
        w_load      = 1'b0;
        case (r_fsm)
            INIT: begin
                w_tms_next = 1'b1;
                if (r_init_cnt == INIT_LAST) begin
                    w_fsm_next = IDLE;
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    if (is_stable(cmd_target)) begin
                        w_load     = 1'b1;
                        w_tms_next = nav_tms(w_tap_next, cmd_target);
                        w_fsm_next = (w_tap_next == cmd_target) ? HOLD : MOVE;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            MOVE: begin
                w_tms_next = nav_tms(w_tap_next, r_tgt);
                if (w_tap_next == r_tgt) begin
                    if (r_hold != '0) begin
                        w_fsm_next = HOLD;
                    end else begin
                        w_fsm_next  = IDLE;
                        w_done_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (r_hold <= HOLD_W'(1)) begin
                    w_fsm_next  = IDLE;
                    w_done_next = 1'b1;
                end
            end
            default: w_fsm_next = INIT;
        endcase
    end

    always_comb begin
        cmd_ready = (r_fsm == IDLE);
        busy      = (r_fsm != IDLE);
    end

    always_ff @(posedge GCLK or posedge TRST) begin
        if (TRST) begin
            r_tms      <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_tgt      <= TLR;
            r_hold     <= '0;
            r_init_cnt <= '0;
        end else begin
            r_tms  <= w_tms_next;
            r_done <= w_done_next;
            r_err  <= w_err_next;
            if (w_load) begin
                r_tgt  <= cmd_target;
                r_hold <= cmd_hold;
            end else if ((r_fsm == HOLD) && (r_hold != '0)) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
            if (r_fsm == INIT) begin
                r_init_cnt <= r_init_cnt + INIT_W'(1);
            end
        end
    end

    assign tms_out   = r_tms;
    assign tap_state = w_tap;
    assign done      = r_done;
    assign err       = r_err;

`ifdef TAP_OBS_CHECK_EN
    // obs_state arrives one register late, so compare it with the delayed shadow.
    tap_state_t r_tap_d;
    logic       r_obs_mismatch;

    always_ff @(posedge GCLK or posedge TRST) begin
        if (TRST) begin
            r_tap_d        <= TLR;
            r_obs_mismatch <= 1'b0;
        end else begin
            r_tap_d <= w_tap;
            if ((r_fsm != INIT) && (obs_state != r_tap_d)) begin
                r_obs_mismatch <= 1'b1;
            end
        end
    end

    assign obs_mismatch = r_obs_mismatch;
`else
    // No observed-state compare in this build.
`endif

endmodule

// File: tb/tb_tap_nav_sequencer.sv
// Scoreboard bench: stimulus queues expected per-cycle observations, a negedge monitor pops and compares.
module tb_tap_nav_sequencer;

    logic       GCLK       = 1'b0;
    logic       TRST       = 1'b1;
    logic       cmd_valid  = 1'b0;
    logic [3:0] cmd_target = 4'h0;
    logic [7:0] cmd_hold   = 8'h0;
    logic       cmd_ready;
    logic       tms_out;
    logic [3:0] tap_state;
    logic       busy;
    logic       done;
    logic       err;

    tap_nav_sequencer #(.HOLD_W(8), .INIT_CYCLES(5)) dut (
        .GCLK       (GCLK),
        .TRST       (TRST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_hold   (cmd_hold),
        .tms_out    (tms_out),
        .tap_state  (tap_state),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 GCLK = ~GCLK;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       ready;
        logic       tms;
        logic [3:0] tap;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_checks  = 0;
    int    n_fail    = 0;
    logic  probe     = 1'b0;
    logic  tmo_flag  = 1'b0;
    logic  final_chk = 1'b0;
    obs_t  act;
    obs_t  exp_e;
    string nm;

    always @(negedge GCLK) begin
        if (tmo_flag) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: %0d expected outputs still pending, required 0", exp_q.size());
        end else if (final_chk) begin
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: %0d expected outputs unconsumed, required 0", exp_q.size());
            end
        end else if (probe || (!TRST && (busy || done || err))) begin
            act = obs_t'({busy, done, err, cmd_ready, tms_out, tap_state});
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected: got busy/done/err/ready/tms=%b%b%b%b%b tap=%h, required no output",
                         act.busy, act.done, act.err, act.ready, act.tms, act.tap);
            end else begin
                exp_e = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (act !== exp_e) begin
                    n_fail++;
                    $display("FAIL %s: got busy/done/err/ready/tms=%b%b%b%b%b tap=%h, required %b%b%b%b%b tap=%h",
                             nm, act.busy, act.done, act.err, act.ready, act.tms, act.tap,
                             exp_e.busy, exp_e.done, exp_e.err, exp_e.ready, exp_e.tms, exp_e.tap);
                end
            end
        end
    end

    task automatic exp_obs(input logic b, input logic d, input logic e, input logic r,
                           input logic t, input logic [3:0] tap, input string name);
        exp_q.push_back(obs_t'({b, d, e, r, t, tap}));
        name_q.push_back(name);
    endtask

    // Busy cycle (INIT/MOVE/HOLD) and completion cycle shorthands.
    task automatic mv(input logic t, input logic [3:0] tap, input string name);
        exp_obs(1'b1, 1'b0, 1'b0, 1'b0, t, tap, name);
    endtask

    task automatic fin(input logic t, input logic [3:0] tap, input string name);
        exp_obs(1'b0, 1'b1, 1'b0, 1'b1, t, tap, name);
    endtask

    // Returns #1 after a rising edge once the queue drains (or the budget runs out).
    task automatic wait_empty(input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
            @(negedge GCLK);
            #1;
        end
        if (exp_q.size() != 0) begin
            tmo_flag = 1'b1;
            @(negedge GCLK);
            #1 tmo_flag = 1'b0;
            exp_q.delete();
            name_q.delete();
        end
        @(posedge GCLK);
        #1;
    endtask

    task automatic issue(input logic [3:0] tgt, input logic [7:0] hold);
        cmd_target = tgt;
        cmd_hold   = hold;
        cmd_valid  = 1'b1;
        @(posedge GCLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic probe_once(input logic b, input logic d, input logic e, input logic r,
                              input logic t, input logic [3:0] tap, input string name);
        exp_obs(b, d, e, r, t, tap, name);
        probe = 1'b1;
        wait_empty(4);
        probe = 1'b0;
    endtask

    initial begin
        probe_once(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, "reset_state");
        for (int i = 0; i < 5; i++) mv(1'b1, 4'hF, "init");
        TRST = 1'b0;
        wait_empty(12);
        probe_once(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, "park_tlr");

        mv(1'b0, 4'hF, "tlr_rti_move");
        fin(1'b0, 4'hC, "tlr_rti_done");
        issue(4'hC, 8'd0);
        wait_empty(12);

        mv(1'b1, 4'hC, "rti_shdr_m0");
        mv(1'b0, 4'h7, "rti_shdr_m1");
        mv(1'b0, 4'h6, "rti_shdr_m2");
        for (int i = 0; i < 3; i++) mv(1'b0, 4'h2, "rti_shdr_hold");
        fin(1'b0, 4'h2, "rti_shdr_done");
        issue(4'h2, 8'd3);
        wait_empty(16);

        mv(1'b1, 4'h2, "shdr_shir_m0");
        mv(1'b1, 4'h1, "shdr_shir_m1");
        mv(1'b1, 4'h5, "shdr_shir_m2");
        mv(1'b1, 4'h7, "shdr_shir_m3");
        mv(1'b0, 4'h4, "shdr_shir_m4");
        mv(1'b0, 4'hE, "shdr_shir_m5");
        fin(1'b0, 4'hA, "shdr_shir_done");
        issue(4'hA, 8'd0);
        wait_empty(16);

        exp_obs(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA, "illegal_err");
        issue(4'h7, 8'd0);
        wait_empty(6);

        // Second request during MOVE must be ignored (its target C would change the path).
        mv(1'b1, 4'hA, "midmove_m0");
        mv(1'b0, 4'h9, "midmove_m1");
        fin(1'b0, 4'hB, "midmove_done");
        cmd_target = 4'hB;
        cmd_hold   = 8'd0;
        cmd_valid  = 1'b1;
        @(posedge GCLK);
        #1 cmd_target = 4'hC;
        cmd_hold = 8'd5;
        @(posedge GCLK);
        #1;
        @(posedge GCLK);
        #1 cmd_valid = 1'b0;
        wait_empty(10);

        mv(1'b0, 4'hB, "same_state_hold");
        mv(1'b0, 4'hB, "same_state_hold");
        fin(1'b0, 4'hB, "same_state_done");
        issue(4'hB, 8'd2);
        wait_empty(10);

        mv(1'b1, 4'hB, "psir_tlr_m0");
        mv(1'b1, 4'h8, "psir_tlr_m1");
        mv(1'b1, 4'hD, "psir_tlr_m2");
        mv(1'b1, 4'h7, "psir_tlr_m3");
        mv(1'b1, 4'h4, "psir_tlr_m4");
        fin(1'b1, 4'hF, "psir_tlr_done");
        issue(4'hF, 8'd0);
        wait_empty(14);

        // Abort a TLR->SHIR walk after two MOVE cycles.
        mv(1'b0, 4'hF, "abort_m0");
        mv(1'b1, 4'hC, "abort_m1");
        issue(4'hA, 8'd0);
        wait_empty(8);
        TRST = 1'b1;
        probe_once(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, "trst_abort");
        for (int i = 0; i < 5; i++) mv(1'b1, 4'hF, "reinit");
        TRST = 1'b0;
        wait_empty(12);
        probe_once(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, "post_reset_idle");

        final_chk = 1'b1;
        @(negedge GCLK);
        #1 final_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
